regbank8: RTL and testbench

Eight-entry register bank that holds the operand values fed to the 8:1 operand selector in the datapath. It provides one write port, two registered read ports with write-to-read bypass, and a hardware bulk-clear sequencer. With ZERO_R0 = 1, entry 0 is hardwired to zero, MIPS-style. The read ports are its consumers' `sel`-indexed view of the eight entries.

---
 rtl/regbank_pkg.sv | 17 +
 rtl/regbank8_mux83.sv | 36 +++
 rtl/regbank8.sv | 155 +++++++++++++++
 tb/tb_regbank8.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared definitions for the regbank8 register bank: address geometry and
// the clear-sequencer state encoding.
package regbank_pkg;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    // Two-state sequencer: normal access, or walking the bulk clear.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Address of the last entry touched by the clear walk.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

endpackage : regbank_pkg

// File: rtl/regbank8_mux83.sv
// Generic 8:1 selector of WIDTH-bit operands, shared with the datapath's
// operand selector. Purely combinational.
module mux83 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_d0,
    input  logic [WIDTH-1:0] i_d1,
    input  logic [WIDTH-1:0] i_d2,
    input  logic [WIDTH-1:0] i_d3,
    input  logic [WIDTH-1:0] i_d4,
    input  logic [WIDTH-1:0] i_d5,
    input  logic [WIDTH-1:0] i_d6,
    input  logic [WIDTH-1:0] i_d7,
    input  logic [2:0]       i_sel,
    output logic [WIDTH-1:0] o_y
);

    // Select one of the eight operands by i_sel.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case statement can infer a latch.
        o_y = '0;
        case (i_sel)
            3'd0:    o_y = i_d0;
            3'd1:    o_y = i_d1;
            3'd2:    o_y = i_d2;
            3'd3:    o_y = i_d3;
            3'd4:    o_y = i_d4;
            3'd5:    o_y = i_d5;
            3'd6:    o_y = i_d6;
            3'd7:    o_y = i_d7;
            default: o_y = '0;
        endcase
    end

endmodule : mux83

// File: rtl/regbank8.sv
// Eight-entry operand register bank: one write port, two registered read
// ports with write-first bypass, and a hardware bulk-clear sequencer that
// zeroes one entry per cycle. With ZERO_R0 = 1 entry 0 is hardwired to zero.
module regbank8
    import regbank_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [2:0]       waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [2:0]       ra1,
    input  logic [2:0]       ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             clr_req,
    output logic             busy
);

    // Sequencer state and clear pointer.
    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   w_cnt_nxt;

    // Effective write for this cycle (external port or clear walk).
    logic                w_eff_we;
    logic [ADDR_W-1:0]   w_eff_addr;
    logic [WIDTH-1:0]    w_eff_data;
    logic                w_wr_commit;

    // Storage and read path.
    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [WIDTH-1:0]    w_mux1;
    logic [WIDTH-1:0]    w_mux2;
    logic [WIDTH-1:0]    w_rd1_nxt;
    logic [WIDTH-1:0]    w_rd2_nxt;

    // State register and clear pointer; reset aborts any clear in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state is always assigned with <= so every flop
            // samples the pre-edge values of its peers.
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and pointer logic: one clear cycle per entry, 0 through 7.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (clr_req) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                // Wraps 7 -> 0 on the exit cycle, so IDLE always sees 0.
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Busy comes straight from the state flop: no input-to-output path.
    assign busy = (r_state == ST_CLEAR);

    // Effective write: the clear walk owns the port while busy, and any
    // external write presented then is simply dropped.
    always_comb begin
        w_eff_we   = we;
        w_eff_addr = waddr;
        w_eff_data = wdata;
        if (r_state == ST_CLEAR) begin
            w_eff_we   = 1'b1;
            w_eff_addr = r_cnt;
            w_eff_data = '0;
        end
    end

    // Writes to entry 0 are discarded when it is hardwired to zero.
    assign w_wr_commit = w_eff_we && !(ZERO_R0 && (w_eff_addr == '0));

    // Storage array update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this storage is plain flops and must read as zero after
            // reset, so every entry is explicitly reset (a RAM macro would not be).
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_commit) begin
            r_mem[w_eff_addr] <= w_eff_data;
        end
    end

    // Read-port selectors over the pre-write contents.
    mux83 #(.WIDTH(WIDTH)) u_mux_rd1 (
        .i_d0  (r_mem[0]),
        .i_d1  (r_mem[1]),
        .i_d2  (r_mem[2]),
        .i_d3  (r_mem[3]),
        .i_d4  (r_mem[4]),
        .i_d5  (r_mem[5]),
        .i_d6  (r_mem[6]),
        .i_d7  (r_mem[7]),
        .i_sel (ra1),
        .o_y   (w_mux1)
    );

    mux83 #(.WIDTH(WIDTH)) u_mux_rd2 (
        .i_d0  (r_mem[0]),
        .i_d1  (r_mem[1]),
        .i_d2  (r_mem[2]),
        .i_d3  (r_mem[3]),
        .i_d4  (r_mem[4]),
        .i_d5  (r_mem[5]),
        .i_d6  (r_mem[6]),
        .i_d7  (r_mem[7]),
        .i_sel (ra2),
        .o_y   (w_mux2)
    );

    // Write-first bypass around each selector. A suppressed entry-0 write
    // never bypasses, and entry 0 itself can never hold anything but zero.
    assign w_rd1_nxt = (w_wr_commit && (w_eff_addr == ra1)) ? w_eff_data : w_mux1;
    assign w_rd2_nxt = (w_wr_commit && (w_eff_addr == ra2)) ? w_eff_data : w_mux2;

    // Registered read outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1 <= '0;
            rd2 <= '0;
        end else begin
            rd1 <= w_rd1_nxt;
            rd2 <= w_rd2_nxt;
        end
    end

endmodule : regbank8

// File: tb/tb_regbank8.sv
// Scoreboard bench for regbank8. Two instances run side by side on the same
// stimulus, one with ZERO_R0 = 0 and one with ZERO_R0 = 1. The stimulus side
// updates an array model of the bank and queues the expected outputs; a
// separate monitor pops and compares after every rising edge.
module tb_regbank8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       we = 1'b0;
    logic [2:0] waddr = '0;
    logic [7:0] wdata = '0;
    logic [2:0] ra1 = '0;
    logic [2:0] ra2 = '0;
    logic       clr_req = 1'b0;

    logic [7:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic       busy_a, busy_b;

    always #5 clk = ~clk;

    regbank8 #(.WIDTH(8), .ZERO_R0(1'b0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a),
        .clr_req(clr_req), .busy(busy_a)
    );

    regbank8 #(.WIDTH(8), .ZERO_R0(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
        .clr_req(clr_req), .busy(busy_b)
    );

    typedef struct packed {
        logic [7:0] r1a;
        logic [7:0] r2a;
        logic [7:0] r1b;
        logic [7:0] r2b;
        logic       bsy;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;

    // Reference model: contents of each bank, and how far a clear has got.
    logic [7:0] m_a [8];
    logic [7:0] m_b [8];
    bit         m_busy;
    int         m_idx;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_a[i] = '0;
            m_b[i] = '0;
        end
        m_busy = 1'b0;
        m_idx  = 0;
    endtask

    // Called at a falling edge: apply inputs, advance the model across the
    // coming rising edge, queue the expected outputs, wait for next fall.
    task automatic drive(input bit w, input logic [2:0] wa, input logic [7:0] wd,
                         input logic [2:0] a1, input logic [2:0] a2, input bit c);
        exp_t e;
        we = w; waddr = wa; wdata = wd; ra1 = a1; ra2 = a2; clr_req = c;
        if (m_busy) begin
            m_a[m_idx] = '0;
            m_b[m_idx] = '0;
            m_idx++;
            if (m_idx == 8) m_busy = 1'b0;
        end else begin
            if (w) begin
                m_a[wa] = wd;
                if (wa != 3'd0) m_b[wa] = wd;
            end
            if (c) begin
                m_busy = 1'b1;
                m_idx  = 0;
            end
        end
        // Write-first: reads see the contents after this edge's write.
        e.r1a = m_a[a1];
        e.r2a = m_a[a2];
        e.r1b = m_b[a1];
        e.r2b = m_b[a2];
        e.bsy = m_busy;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle_read(input logic [2:0] a1, input logic [2:0] a2);
        drive(1'b0, 3'd0, 8'h00, a1, a2, 1'b0);
    endtask

    // Called at a falling edge: assert reset, check outputs immediately,
    // release two cycles later at a falling edge.
    task automatic do_reset();
        mon_en = 1'b0;
        we = 1'b0; clr_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_rd1_a", rd1_a, 8'h00);
        check("rst_rd2_a", rd2_a, 8'h00);
        check("rst_rd1_b", rd1_b, 8'h00);
        check("rst_rd2_b", rd2_b, 8'h00);
        check("rst_busy_a", {7'd0, busy_a}, 8'h00);
        check("rst_busy_b", {7'd0, busy_b}, 8'h00);
        model_reset();
        q.delete();
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    // Monitor: the read ports present a new result after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL queue_empty actual=0 entries required=1 at %0t", $time);
                end else begin
                    e = q.pop_front();
                    check("rd1_a", rd1_a, e.r1a);
                    check("rd2_a", rd2_a, e.r2a);
                    check("rd1_b", rd1_b, e.r1b);
                    check("rd2_b", rd2_b, e.r2b);
                    check("busy_a", {7'd0, busy_a}, {7'd0, e.bsy});
                    check("busy_b", {7'd0, busy_b}, {7'd0, e.bsy});
                end
            end
        end
    end

    initial begin
        logic [7:0] vals [8];
        vals[0] = 8'h3C; vals[1] = 8'd7; vals[2] = 8'd5; vals[3] = 8'd3;
        vals[4] = 8'd2;  vals[5] = 8'd5; vals[6] = 8'd3; vals[7] = 8'd6;
        model_reset();

        @(negedge clk);
        do_reset();

        // Write/read: fill, then sweep ra1 up and ra2 down.
        for (int i = 0; i < 8; i++) drive(1'b1, 3'(i), vals[i], 3'(7 - i), 3'(i), 1'b0);
        drive(1'b1, 3'd7, 8'd1, 3'd0, 3'd0, 1'b0);
        for (int i = 0; i < 8; i++) idle_read(3'(i), 3'(7 - i));

        // Mid-run reset with nonzero contents, then everything reads zero.
        do_reset();
        for (int i = 0; i < 8; i++) idle_read(3'(i), 3'(7 - i));
        for (int i = 1; i < 8; i++) drive(1'b1, 3'(i), 8'(i * 17), 3'(i), 3'(i), 1'b0);

        // Bypass: write and read the same address in one cycle.
        drive(1'b1, 3'd3, 8'hA5, 3'd3, 3'd1, 1'b0);
        idle_read(3'd3, 3'd3);

        // Entry 0: written and read together, then read again.
        drive(1'b1, 3'd0, 8'hFF, 3'd0, 3'd0, 1'b0);
        idle_read(3'd0, 3'd0);

        // Clear with a same-cycle write, then writes and a second request
        // while busy; afterwards sweep all addresses.
        drive(1'b1, 3'd2, 8'h55, 3'd2, 3'd2, 1'b1);
        for (int i = 0; i < 8; i++) drive(1'b1, 3'd4, 8'h99, 3'(i), 3'd4, (i == 3));
        for (int i = 0; i < 8; i++) idle_read(3'(i), 3'(7 - i));
        idle_read(3'd4, 3'd2);

        // Reset in the middle of a clear, then normal write/read.
        for (int i = 0; i < 8; i++) drive(1'b1, 3'(i), 8'hC0 + 8'(i), 3'(i), 3'(i), 1'b0);
        drive(1'b0, 3'd0, 8'h00, 3'd5, 3'd6, 1'b1);
        for (int i = 0; i < 4; i++) idle_read(3'd6, 3'd7);
        do_reset();
        drive(1'b1, 3'd5, 8'hC3, 3'd5, 3'd6, 1'b0);
        idle_read(3'd5, 3'd6);
        for (int i = 0; i < 8; i++) idle_read(3'(i), 3'(i));

        // Randomised traffic, including occasional clears.
        for (int n = 0; n < 500; n++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 39) == 0));
        end
        for (int i = 0; i < 10; i++) idle_read(3'(i % 8), 3'(7 - (i % 8)));

        mon_en = 1'b0;
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL queue_drain actual=%0d entries required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_regbank8
